// File: rtl/tod_pkg.sv
// Shared limits, load_time field offsets and BCD helpers for the time-of-day counter.
package tod_pkg;

  localparam int SEC_MAX    = 59;
  localparam int MIN_MAX    = 59;
  localparam int HOUR24_MAX = 23;
  localparam int HOUR12_MAX = 12;

  // LSB offsets of each digit inside load_time
  localparam int LT_SEC_UNITS  = 0;
  localparam int LT_SEC_TENS   = 4;
  localparam int LT_MIN_UNITS  = 7;
  localparam int LT_MIN_TENS   = 11;
  localparam int LT_HOUR_UNITS = 14;
  localparam int LT_HOUR_TENS  = 18;
  localparam int LT_W          = 20;

  typedef logic [3:0] bcd_t;

  function automatic logic bcd_ok(input int tens, input int units, input int max_val);
    return (units <= 9) && (tens * 10 + units <= max_val);
  endfunction

endpackage

// File: rtl/bcd_digit_ctr.sv
// Single modulo-MOD digit with sync clear/load and wrapping up/down count.
module bcd_digit_ctr #(
  parameter int             MOD     = 10,
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] digit,
  output logic         at_max,
  output logic         at_zero
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  always_ff @(posedge clk) begin
    if (reset)
      digit <= RST_VAL;
    else if (clr)
      digit <= '0;
    else if (load)
      digit <= load_val;
    else if (inc && !dec)
      digit <= (digit == TOP) ? '0 : digit + 1'b1;
    else if (dec && !inc)
      digit <= (digit == '0) ? TOP : digit - 1'b1;
  end

  assign at_max  = (digit == TOP);
  assign at_zero = (digit == '0);

endmodule

// File: rtl/tod_counter.sv
// BCD time-of-day counter (12/24-hour) with minute/hour adjust, AM/PM and midnight pulse.
// Optional preset port pair load/load_time is built when TOD_PRESET_EN is defined.
module tod_counter
  import tod_pkg::*;
#(
  parameter int HOUR24      = 1,
  parameter int ADJ_CLR_SEC = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        c_up_min,
  input  logic        c_down_min,
  input  logic        c_up_hour,
  input  logic        c_down_hour,
`ifdef TOD_PRESET_EN
  input  logic        load,
  input  logic [19:0] load_time,
`endif
  output logic [3:0]  sec_units,
  output logic [2:0]  sec_tens,
  output logic [3:0]  min_units,
  output logic [2:0]  min_tens,
  output logic [3:0]  hour_units,
  output logic [1:0]  hour_tens,
  output logic        pm,
  output logic        day_tick
);

  localparam bit         MODE24 = (HOUR24 != 0);
  localparam logic [1:0] HT_RST = MODE24 ? 2'd0 : 2'd1;
  localparam bcd_t       HU_RST = MODE24 ? 4'd0 : 4'd2;
  localparam bcd_t       HU_UPW = MODE24 ? 4'd0 : 4'd1;
  localparam logic [1:0] HT_DNW = MODE24 ? 2'd2 : 2'd1;
  localparam bcd_t       HU_DNW = MODE24 ? 4'd3 : 4'd2;

  logic su_max, su_zero, st_max, st_zero, mu_max, mu_zero, mt_max, mt_zero;
  logic hu_max, hu_zero, ht_max, ht_zero;
  logic ld_go, ld_ok, ld_pm, ld_take;
  logic [1:0] ld_ht;
  logic [2:0] ld_mt, ld_st;
  bcd_t ld_hu, ld_mu, ld_su;
  logic adj, tick, bad, fix, step;
  logic s59, m59, h_11, h_12, h_23, h_top, h_bot;
  logic min_up, min_dn, min_inc, hr_up, hr_dn, carry_h, wrap_up, wrap_dn;
  logic sec_clr, hr_load;
  logic [1:0] hr_ht_val;
  bcd_t hr_hu_val;

`ifdef TOD_PRESET_EN
  int ld_h24, ld_h12;

  // load_time hours are always 24-hour encoded; fold to 12-hour form here
  always_comb begin
    ld_h24 = int'(load_time[LT_HOUR_TENS +: 2]) * 10 + int'(load_time[LT_HOUR_UNITS +: 4]);
    ld_h12 = (ld_h24 == 0) ? 12 : (ld_h24 > 12) ? ld_h24 - 12 : ld_h24;
    ld_go  = load;
    ld_ok  = bcd_ok(int'(load_time[LT_HOUR_TENS +: 2]), int'(load_time[LT_HOUR_UNITS +: 4]), HOUR24_MAX) &&
             bcd_ok(int'(load_time[LT_MIN_TENS +: 3]), int'(load_time[LT_MIN_UNITS +: 4]), MIN_MAX) &&
             bcd_ok(int'(load_time[LT_SEC_TENS +: 3]), int'(load_time[LT_SEC_UNITS +: 4]), SEC_MAX);
    ld_pm  = (ld_h24 >= 12);
    ld_mt  = load_time[LT_MIN_TENS +: 3];
    ld_mu  = load_time[LT_MIN_UNITS +: 4];
    ld_st  = load_time[LT_SEC_TENS +: 3];
    ld_su  = load_time[LT_SEC_UNITS +: 4];
    if (MODE24) begin
      ld_ht = load_time[LT_HOUR_TENS +: 2];
      ld_hu = load_time[LT_HOUR_UNITS +: 4];
    end else begin
      ld_ht = (ld_h12 >= 10) ? 2'd1 : 2'd0;
      ld_hu = bcd_t'(ld_h12 - ((ld_h12 >= 10) ? 10 : 0));
    end
  end
`else
  always_comb begin
    ld_go = 1'b0;
    ld_ok = 1'b0;
    ld_pm = 1'b0;
    ld_ht = '0;
    ld_hu = '0;
    ld_mt = '0;
    ld_mu = '0;
    ld_st = '0;
    ld_su = '0;
  end
`endif

  always_comb begin
    adj     = c_up_min | c_down_min | c_up_hour | c_down_hour;
    tick    = en & ~adj & ~ld_go;
    bad     = !bcd_ok(int'(sec_tens), int'(sec_units), SEC_MAX) ||
              !bcd_ok(int'(min_tens), int'(min_units), MIN_MAX) ||
              (MODE24 ? !bcd_ok(int'(hour_tens), int'(hour_units), HOUR24_MAX)
                      : (!bcd_ok(int'(hour_tens), int'(hour_units), HOUR12_MAX) || (ht_zero && hu_zero)));
    fix     = tick & bad;
    step    = tick & ~bad;
    ld_take = ld_go & ld_ok;
    s59     = st_max & su_max;
    m59     = mt_max & mu_max;
    h_11    = (hour_tens == 2'd1) && (hour_units == 4'd1);
    h_12    = (hour_tens == 2'd1) && (hour_units == 4'd2);
    h_23    = ht_max && (hour_units == 4'd3);
    h_top   = MODE24 ? h_23 : h_12;
    h_bot   = MODE24 ? (ht_zero && hu_zero) : (ht_zero && (hour_units == 4'd1));
    min_up  = ~ld_go & c_up_min & ~c_down_min;
    min_dn  = ~ld_go & c_down_min & ~c_up_min;
    min_inc = (step & s59) | min_up;
    carry_h = step & s59 & m59;
    hr_up   = carry_h | (~ld_go & c_up_hour & ~c_down_hour);
    hr_dn   = ~ld_go & c_down_hour & ~c_up_hour;
    wrap_up = hr_up & h_top;
    wrap_dn = hr_dn & h_bot;
    sec_clr = fix | ((ADJ_CLR_SEC != 0) & adj & ~ld_go & ~(su_zero & st_zero));
    hr_load = ld_take | fix | wrap_up | wrap_dn;
    if (ld_take) begin
      hr_ht_val = ld_ht;
      hr_hu_val = ld_hu;
    end else if (fix) begin
      hr_ht_val = HT_RST;
      hr_hu_val = HU_RST;
    end else if (wrap_up) begin
      hr_ht_val = 2'd0;
      hr_hu_val = HU_UPW;
    end else begin
      hr_ht_val = HT_DNW;
      hr_hu_val = HU_DNW;
    end
  end

  bcd_digit_ctr #(.MOD(10), .W(4)) u_sec_units (
    .clk(clk), .reset(reset), .clr(sec_clr), .load(ld_take), .load_val(ld_su),
    .inc(step), .dec(1'b0), .digit(sec_units), .at_max(su_max), .at_zero(su_zero));

  bcd_digit_ctr #(.MOD(6), .W(3)) u_sec_tens (
    .clk(clk), .reset(reset), .clr(sec_clr), .load(ld_take), .load_val(ld_st),
    .inc(step & su_max), .dec(1'b0), .digit(sec_tens), .at_max(st_max), .at_zero(st_zero));

  bcd_digit_ctr #(.MOD(10), .W(4)) u_min_units (
    .clk(clk), .reset(reset), .clr(fix), .load(ld_take), .load_val(ld_mu),
    .inc(min_inc), .dec(min_dn), .digit(min_units), .at_max(mu_max), .at_zero(mu_zero));

  bcd_digit_ctr #(.MOD(6), .W(3)) u_min_tens (
    .clk(clk), .reset(reset), .clr(fix), .load(ld_take), .load_val(ld_mt),
    .inc(min_inc & mu_max), .dec(min_dn & mu_zero), .digit(min_tens), .at_max(mt_max), .at_zero(mt_zero));

  // hour digits count freely inside the range; the pair wrap points are loaded explicitly
  bcd_digit_ctr #(.MOD(10), .W(4), .RST_VAL(HU_RST)) u_hour_units (
    .clk(clk), .reset(reset), .clr(1'b0), .load(hr_load), .load_val(hr_hu_val),
    .inc(hr_up & ~h_top), .dec(hr_dn & ~h_bot), .digit(hour_units), .at_max(hu_max), .at_zero(hu_zero));

  bcd_digit_ctr #(.MOD(3), .W(2), .RST_VAL(HT_RST)) u_hour_tens (
    .clk(clk), .reset(reset), .clr(1'b0), .load(hr_load), .load_val(hr_ht_val),
    .inc(hr_up & ~h_top & hu_max), .dec(hr_dn & ~h_bot & hu_zero),
    .digit(hour_tens), .at_max(ht_max), .at_zero(ht_zero));

  always_ff @(posedge clk) begin
    if (reset) begin
      pm       <= 1'b0;
      day_tick <= 1'b0;
    end else begin
      day_tick <= carry_h & (MODE24 ? h_23 : (h_11 & pm));
      if (ld_take)
        pm <= ld_pm;
      else if (fix)
        pm <= 1'b0;
      else if (hr_up) begin
        if (h_11)
          pm <= MODE24 ? 1'b1 : ~pm;
        else if (MODE24 && h_23)
          pm <= 1'b0;
      end else if (hr_dn) begin
        if (h_12)
          pm <= MODE24 ? 1'b0 : ~pm;
        else if (MODE24 && h_bot)
          pm <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tod_counter.sv
// Bench for tod_counter: 24-hour and 12-hour instances share stimulus and one time-of-day model.
module tb_tod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, c_up_min, c_down_min, c_up_hour, c_down_hour, load;
  logic [19:0] load_time;

  logic [3:0] a_su, a_mu, a_hu, b_su, b_mu, b_hu;
  logic [2:0] a_st, a_mt, b_st, b_mt;
  logic [1:0] a_ht, b_ht;
  logic a_pm, a_dt, b_pm, b_dt;
  logic [21:0] a_vec, b_vec;
  assign a_vec = {a_ht, a_hu, a_mt, a_mu, a_st, a_su, a_pm, a_dt};
  assign b_vec = {b_ht, b_hu, b_mt, b_mu, b_st, b_su, b_pm, b_dt};

  tod_counter #(.HOUR24(1)) dut24 (
    .clk(clk), .reset(reset), .en(en), .c_up_min(c_up_min), .c_down_min(c_down_min),
    .c_up_hour(c_up_hour), .c_down_hour(c_down_hour),
`ifdef TOD_PRESET_EN
    .load(load), .load_time(load_time),
`endif
    .sec_units(a_su), .sec_tens(a_st), .min_units(a_mu), .min_tens(a_mt),
    .hour_units(a_hu), .hour_tens(a_ht), .pm(a_pm), .day_tick(a_dt));

  tod_counter #(.HOUR24(0)) dut12 (
    .clk(clk), .reset(reset), .en(en), .c_up_min(c_up_min), .c_down_min(c_down_min),
    .c_up_hour(c_up_hour), .c_down_hour(c_down_hour),
`ifdef TOD_PRESET_EN
    .load(load), .load_time(load_time),
`endif
    .sec_units(b_su), .sec_tens(b_st), .min_units(b_mu), .min_tens(b_mt),
    .hour_units(b_hu), .hour_tens(b_ht), .pm(b_pm), .day_tick(b_dt));

  // model keeps the time as a 24-hour h/m/s triple; 12-hour display is derived from it
  int m_h, m_m, m_s;
  logic m_dt;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int   rep;
    logic r, e, um, dm, uh, dh;
    int   h, m, s;
    logic dt;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [21:0] exp_vec(input bit mode24, input int h, input int m, input int s, input logic dt);
    int hd;
    hd = mode24 ? h : (((h % 12) == 0) ? 12 : (h % 12));
    return {2'(hd / 10), 4'(hd % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), (h >= 12), dt};
  endfunction

  function automatic logic [19:0] pack(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic void add(input int rep, input logic r, input logic e, input logic um, input logic dm,
                              input logic uh, input logic dh, input int h, input int m, input int s, input logic dt);
    vec_t v;
    v.rep = rep; v.r = r; v.e = e; v.um = um; v.dm = dm; v.uh = uh; v.dh = dh;
    v.h = h; v.m = m; v.s = s; v.dt = dt;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dut={ht,hu,mt,mu,st,su,pm,dt}=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic model_update();
    int t, lh, lm, ls;
    if (reset) begin
      m_h = 0; m_m = 0; m_s = 0; m_dt = 1'b0;
    end else if (load) begin
      m_dt = 1'b0;
      lh = int'(load_time[19:18]) * 10 + int'(load_time[17:14]);
      lm = int'(load_time[13:11]) * 10 + int'(load_time[10:7]);
      ls = int'(load_time[6:4]) * 10 + int'(load_time[3:0]);
      if (load_time[17:14] <= 9 && load_time[10:7] <= 9 && load_time[3:0] <= 9 &&
          lh <= 23 && lm <= 59 && ls <= 59) begin
        m_h = lh; m_m = lm; m_s = ls;
      end
    end else begin
      m_dt = 1'b0;
      if (c_up_min | c_down_min | c_up_hour | c_down_hour) begin
        m_m = (m_m + int'(c_up_min) - int'(c_down_min) + 60) % 60;
        m_h = (m_h + int'(c_up_hour) - int'(c_down_hour) + 24) % 24;
      end else if (en) begin
        t = m_h * 3600 + m_m * 60 + m_s + 1;
        if (t == 86400) begin
          t = 0;
          m_dt = 1'b1;
        end
        m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("model24", a_vec, exp_vec(1'b1, m_h, m_m, m_s, m_dt));
    check("model12", b_vec, exp_vec(1'b0, m_h, m_m, m_s, m_dt));
  endtask

  task automatic drive(input logic r, input logic e, input logic um, input logic dm, input logic uh, input logic dh);
    reset = r; en = e; c_up_min = um; c_down_min = dm; c_up_hour = uh; c_down_hour = dh;
  endtask

  int dt24, dt12;

  initial begin
    load = 1'b0;
    load_time = '0;
    drive(1'b1, 0, 0, 0, 0, 0);
    m_h = 0; m_m = 0; m_s = 0; m_dt = 1'b0;

    //   rep  r  e um dm uh dh    h   m   s  dt
    add(1,   1, 0, 0, 0, 0, 0,   0,  0,  0, 0);
    add(10,  0, 0, 0, 0, 1, 0,  10,  0,  0, 0);
    add(30,  0, 1, 0, 0, 0, 0,  10,  0, 30, 0);
    add(1,   0, 0, 0, 1, 0, 0,  10, 59, 30, 0);
    add(14,  0, 0, 0, 0, 1, 0,   0, 59, 30, 0);
    add(1,   0, 1, 0, 0, 1, 1,   0, 59, 30, 0);
    add(1,   1, 0, 0, 0, 0, 0,   0,  0,  0, 0);
    add(5,   0, 0, 0, 0, 1, 0,   5,  0,  0, 0);
    add(7,   0, 0, 1, 0, 0, 0,   5,  7,  0, 0);
    add(9,   0, 1, 0, 0, 0, 0,   5,  7,  9, 0);
    add(1,   0, 1, 1, 0, 0, 0,   5,  8,  9, 0);
    add(1,   0, 0, 1, 1, 0, 0,   5,  8,  9, 0);
    add(1,   0, 0, 1, 0, 1, 0,   6,  9,  9, 0);
    add(7,   0, 0, 0, 0, 0, 1,  23,  9,  9, 0);
    add(50,  0, 0, 1, 0, 0, 0,  23, 59,  9, 0);
    add(50,  0, 1, 0, 0, 0, 0,  23, 59, 59, 0);
    add(1,   1, 1, 0, 0, 0, 0,   0,  0,  0, 0);
    add(1,   0, 0, 0, 0, 0, 1,  23,  0,  0, 0);
    add(1,   0, 0, 0, 1, 0, 0,  23, 59,  0, 0);
    add(59,  0, 1, 0, 0, 0, 0,  23, 59, 59, 0);
    add(1,   0, 1, 0, 0, 0, 0,   0,  0,  0, 1);
    add(1,   0, 1, 0, 0, 0, 0,   0,  0,  1, 0);
    add(1,   1, 0, 0, 0, 0, 0,   0,  0,  0, 0);
    add(13,  0, 0, 0, 0, 0, 1,  11,  0,  0, 0);
    add(1,   0, 0, 0, 1, 0, 0,  11, 59,  0, 0);
    add(59,  0, 1, 0, 0, 0, 0,  11, 59, 59, 0);
    add(1,   0, 1, 0, 0, 0, 0,  12,  0,  0, 0);
    add(1,   0, 0, 0, 0, 0, 1,  11,  0,  0, 0);
    add(1,   0, 0, 0, 0, 1, 0,  12,  0,  0, 0);
    add(1,   0, 0, 0, 1, 0, 0,  12, 59,  0, 0);
    add(1,   1, 0, 0, 0, 0, 0,   0,  0,  0, 0);
    add(1,   0, 0, 0, 0, 1, 0,   1,  0,  0, 0);
    add(1,   0, 0, 0, 0, 0, 1,   0,  0,  0, 0);
    add(1,   0, 0, 0, 0, 0, 1,  23,  0,  0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].um, tbl[i].dm, tbl[i].uh, tbl[i].dh);
      repeat (tbl[i].rep) cycle();
      check($sformatf("row%0d_24", i), a_vec, exp_vec(1'b1, tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].dt));
      check($sformatf("row%0d_12", i), b_vec, exp_vec(1'b0, tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].dt));
    end

    // long runs: an hour of ticks across noon, then across midnight
    drive(1, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 1, 0); repeat (11) cycle();
    drive(0, 1, 0, 0, 0, 0); repeat (3600) cycle();
    check("noon24", a_vec, exp_vec(1'b1, 12, 0, 0, 1'b0));
    check("noon12", b_vec, exp_vec(1'b0, 12, 0, 0, 1'b0));
    drive(0, 0, 0, 0, 1, 0); repeat (11) cycle();
    drive(0, 1, 0, 0, 0, 0);
    dt24 = 0; dt12 = 0;
    repeat (3600) begin
      cycle();
      if (a_dt) dt24++;
      if (b_dt) dt12++;
    end
    check("midnight24", a_vec, exp_vec(1'b1, 0, 0, 0, 1'b1));
    check("midnight12", b_vec, exp_vec(1'b0, 0, 0, 0, 1'b1));
    check_int("day_tick_count24", dt24, 1);
    check_int("day_tick_count12", dt12, 1);

`ifdef TOD_PRESET_EN
    drive(0, 0, 0, 0, 0, 0);
    load = 1'b1; load_time = pack(13, 45, 0); cycle();
    check("load24", a_vec, exp_vec(1'b1, 13, 45, 0, 1'b0));
    check("load12", b_vec, exp_vec(1'b0, 13, 45, 0, 1'b0));
    drive(0, 1, 0, 0, 1, 0);
    load_time = pack(24, 0, 0); cycle();
    check("load_bad24", a_vec, exp_vec(1'b1, 13, 45, 0, 1'b0));
    check("load_bad12", b_vec, exp_vec(1'b0, 13, 45, 0, 1'b0));
    load_time = pack(0, 30, 15); cycle();
    check("load_mid24", a_vec, exp_vec(1'b1, 0, 30, 15, 1'b0));
    check("load_mid12", b_vec, exp_vec(1'b0, 0, 30, 15, 1'b0));
    load = 1'b0;
`endif

    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(199) == 0);
      en          = $urandom_range(1) == 1;
      c_up_min    = ($urandom_range(7) == 0);
      c_down_min  = ($urandom_range(7) == 0);
      c_up_hour   = ($urandom_range(7) == 0);
      c_down_hour = ($urandom_range(7) == 0);
`ifdef TOD_PRESET_EN
      load = ($urandom_range(49) == 0);
      if ($urandom_range(1) == 1)
        load_time = pack($urandom_range(23), $urandom_range(59), $urandom_range(59));
      else
        load_time = 20'($urandom());
`endif
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
